// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto one single-outstanding memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants on contention; default is fixed data priority.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic        I_GNT,
  output logic        I_VALID,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  input  logic [3:0]  D_WMASK,
  output logic        D_GNT,
  output logic        D_VALID,
  output logic [31:0] RDATA,
  output logic        BUS_ERR,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WDATA,
  output logic [3:0]  M_WMASK,
  input  logic        M_ACK,
  input  logic [31:0] M_RDATA
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic       owner_d;
  logic       pick_d;
  logic       in_idle;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;

  // On contention the side that did not win last time gets the bus.
  always_comb pick_d = D_REQ && (!I_REQ || !last_d);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      last_d <= 1'b1;
    else if (I_GNT || D_GNT)
      last_d <= D_GNT;
  end
`else
  always_comb pick_d = D_REQ;
`endif

  // Grants are gated by reset so nothing is accepted while the FSM is held.
  assign in_idle = (state == IDLE) && RESET_N;
  assign I_GNT   = in_idle && I_REQ && !pick_d;
  assign D_GNT   = in_idle && pick_d;
  assign I_VALID = (state == RESP) && !owner_d;
  assign D_VALID = (state == RESP) && owner_d;
  assign M_REQ   = (state == BUSY);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      wait_cnt <= '0;
      owner_d  <= 1'b0;
      M_WE     <= 1'b0;
      M_ADDR   <= '0;
      M_WDATA  <= '0;
      M_WMASK  <= '0;
      RDATA    <= '0;
      BUS_ERR  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I_GNT || D_GNT) begin
            owner_d  <= D_GNT;
            M_WE     <= D_GNT && D_WE;
            M_ADDR   <= D_GNT ? D_ADDR : I_ADDR;
            M_WDATA  <= D_GNT ? D_WDATA : '0;
            M_WMASK  <= D_GNT ? D_WMASK : '0;
            wait_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // An ack in the final wait cycle still counts as a normal completion.
          if (M_ACK) begin
            RDATA   <= M_WE ? '0 : M_RDATA;
            BUS_ERR <= 1'b0;
            state   <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            RDATA   <= '0;
            BUS_ERR <= 1'b1;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus contention,
// spurious-ack and reset-during-BUSY sequences; responses checked through a scoreboard queue.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        I_REQ, D_REQ, D_WE, M_ACK;
  logic [31:0] I_ADDR, D_ADDR, D_WDATA, M_RDATA;
  logic [3:0]  D_WMASK;
  logic        I_GNT, I_VALID, D_GNT, D_VALID, BUS_ERR, M_REQ, M_WE;
  logic [31:0] RDATA, M_ADDR, M_WDATA;
  logic [3:0]  M_WMASK;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_VALID(I_VALID),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_WMASK(D_WMASK),
    .D_GNT(D_GNT), .D_VALID(D_VALID), .RDATA(RDATA), .BUS_ERR(BUS_ERR),
    .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_WMASK(M_WMASK),
    .M_ACK(M_ACK), .M_RDATA(M_RDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          delay;      // BUSY cycle in which memory acks, 0 = never
    logic [31:0] mrdata;
    int          exp_len;    // cycles M_REQ stays high
    logic [31:0] exp_rdata;
    logic        exp_err;
  } txn_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       sb[$];
  txn_t        tbl[8];
  int          n_checks = 0;
  int          n_err = 0;
  int          mem_delay = 0;
  int          busy_cnt = 0;
  int          last_len = 0;
  logic [31:0] mem_rdata = '0;
  logic        force_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: scoreboard pop on VALID, then the memory model decides M_ACK for this cycle.
  task automatic tick();
    resp_t e;
    @(negedge CLK);
    #1;
    if (I_VALID || D_VALID) begin
      if (sb.size() == 0) begin
        chk("valid_unexpected", {30'd0, I_VALID, D_VALID}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("valid_owner", {30'd0, I_VALID, D_VALID}, e.is_d ? 32'd1 : 32'd2);
        chk("rdata", RDATA, e.rdata);
        chk("bus_err", {31'd0, BUS_ERR}, {31'd0, e.err});
      end
    end
    if (M_REQ) begin
      busy_cnt++;
      M_ACK = force_ack || (mem_delay != 0 && busy_cnt == mem_delay);
    end else begin
      if (busy_cnt != 0) last_len = busy_cnt;
      busy_cnt = 0;
      M_ACK = force_ack;
    end
    M_RDATA = M_ACK ? mem_rdata : $urandom();
  endtask

  task automatic run_txn(input txn_t t);
    tick();
    last_len  = 0;
    mem_delay = t.delay;
    mem_rdata = t.mrdata;
    I_REQ   = !t.is_d;
    D_REQ   = t.is_d;
    I_ADDR  = t.addr;
    D_ADDR  = t.addr;
    D_WE    = t.we;
    D_WDATA = t.wdata;
    D_WMASK = t.wmask;
    #1;
    chk("gnt", {30'd0, I_GNT, D_GNT}, t.is_d ? 32'd1 : 32'd2);
    sb.push_back('{is_d: t.is_d, rdata: t.exp_rdata, err: t.exp_err});
    tick();
    I_REQ = 1'b0; D_REQ = 1'b0;
    D_WE = 1'($urandom()); D_ADDR = $urandom(); I_ADDR = $urandom();
    D_WDATA = $urandom(); D_WMASK = 4'($urandom());
    #1;
    chk("m_req", {31'd0, M_REQ}, 32'd1);
    chk("m_addr", M_ADDR, t.addr);
    chk("m_we", {31'd0, M_WE}, {31'd0, t.is_d && t.we});
    if (t.is_d && t.we) begin
      chk("m_wdata", M_WDATA, t.wdata);
      chk("m_wmask", {28'd0, M_WMASK}, {28'd0, t.wmask});
    end
    for (int k = 0; k < 300 && M_REQ; k++) tick();
    chk("m_req_len", last_len, t.exp_len);
    chk("resp_seen", sb.size(), 0);
    tick();
    chk("rdata_hold", RDATA, t.exp_rdata);
    chk("err_hold", {31'd0, BUS_ERR}, {31'd0, t.exp_err});
    chk("valid_once", {30'd0, I_VALID, D_VALID}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  exp_seq [5];
    logic [31:0] exp_addr, prev_rdata;
    logic        chk_addr, drop_d, drop_i;
    int          grants, last_c;

    //              is_d we  addr         wdata         wmask dly mrdata        len rdata         err
    tbl[0] = '{1'b1, 1'b0, 32'h100,  32'h0,        4'h0, 3, 32'hDEADBEEF, 3, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 32'h200,  32'h12345678, 4'h3, 1, 32'hAAAA5555, 1, 32'h0,        1'b0};
    tbl[2] = '{1'b0, 1'b0, 32'h4000, 32'h0,        4'h0, 1, 32'h13579BDF, 1, 32'h13579BDF, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 32'h4004, 32'h0,        4'h0, 0, 32'h11111111, 4, 32'h0,        1'b1};
    tbl[4] = '{1'b1, 1'b0, 32'h300,  32'h0,        4'h0, 4, 32'hCAFEF00D, 4, 32'hCAFEF00D, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h304,  32'h0,        4'h0, 5, 32'h22222222, 4, 32'h0,        1'b1};
    tbl[6] = '{1'b1, 1'b1, 32'h308,  32'hA5A5A5A5, 4'hF, 2, 32'h33333333, 2, 32'h0,        1'b0};
    tbl[7] = '{1'b0, 1'b0, 32'h4008, 32'h0,        4'h0, 2, 32'h0BADF00D, 2, 32'h0BADF00D, 1'b0};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`endif

    RESET_N = 1'b0;
    I_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0; M_ACK = 1'b0;
    I_ADDR = '0; D_ADDR = '0; D_WDATA = '0; D_WMASK = '0; M_RDATA = '0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_gnt_valid", {28'd0, I_GNT, D_GNT, I_VALID, D_VALID}, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_err_mreq_mwe", {29'd0, BUS_ERR, M_REQ, M_WE}, 32'd0);
    chk("rst_m_addr", M_ADDR, 32'd0);
    chk("rst_m_wdata", M_WDATA, 32'd0);
    chk("rst_m_wmask", {28'd0, M_WMASK}, 32'd0);
    RESET_N = 1'b1;

    // Both requesters held: grant order and the 3-cycle grant spacing.
    tick();
    mem_delay = 1;
    I_ADDR = 32'h1000; D_ADDR = 32'h2000; D_WE = 1'b0;
    I_REQ = 1'b1; D_REQ = 1'b1;
    grants = 0; last_c = 0; chk_addr = 1'b0; drop_d = 1'b0; drop_i = 1'b0; exp_addr = '0;
    for (int c = 0; c < 60 && grants < 5; c++) begin
      if (c > 0) begin
        tick();
        if (drop_d) D_REQ = 1'b0;
        if (drop_i) I_REQ = 1'b0;
        drop_d = 1'b0; drop_i = 1'b0;
        if (chk_addr) chk("cont_m_addr", M_ADDR, exp_addr);
        chk_addr = 1'b0;
      end
      mem_rdata = 32'h600D0000 + 32'(grants);
      #1;
      if (I_GNT || D_GNT) begin
        chk("cont_gnt", {30'd0, I_GNT, D_GNT}, {30'd0, exp_seq[grants]});
        if (grants > 0) chk("cont_spacing", c - last_c, 3);
        last_c = c;
        sb.push_back('{is_d: exp_seq[grants] == 2'b01, rdata: mem_rdata, err: 1'b0});
        exp_addr = (exp_seq[grants] == 2'b01) ? 32'h2000 : 32'h1000;
        chk_addr = 1'b1;
        if (grants == 3) drop_d = 1'b1;
        if (grants == 4) drop_i = 1'b1;
        grants++;
      end
    end
    chk("cont_grants", grants, 5);
    tick();
    I_REQ = 1'b0; D_REQ = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    chk("cont_drain", sb.size(), 0);

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Ack pulsed while idle must be ignored.
    tick();
    prev_rdata = RDATA;
    mem_rdata = 32'hFEEDFACE;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("spur_novalid", {29'd0, I_VALID, D_VALID, M_REQ}, 32'd0);
    end
    chk("spur_rdata_hold", RDATA, prev_rdata);
    run_txn(tbl[7]);

    // Reset pulse in the middle of a fetch: abort with no response.
    tick();
    mem_delay = 0;
    I_ADDR = 32'h5000; I_REQ = 1'b1;
    #1;
    chk("rst_busy_gnt", {30'd0, I_GNT, D_GNT}, 32'd2);
    tick();
    I_REQ = 1'b0;
    #1;
    chk("rst_busy_mreq", {31'd0, M_REQ}, 32'd1);
    tick();
    RESET_N = 1'b0;
    #1;
    chk("rst_abort_mreq", {31'd0, M_REQ}, 32'd0);
    chk("rst_abort_maddr", M_ADDR, 32'd0);
    tick();
    RESET_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_novalid", {30'd0, I_VALID, D_VALID}, 32'd0);
    end
    run_txn(tbl[2]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
